// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_mem_ctrl_pkg;

   // Controller phases; the bench monitors reuse this enum.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      DONE  = 3'd5
   } state_t;

   // CPU byte address that lands on SRAM half-word 0.
   localparam int MEM_ADDR_BASE = 1024;

endpackage

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller: each 32-bit CPU access becomes two
// 16-bit SRAM transactions (low half first); ready stalls the pipeline.
module sram_mem_ctrl
   import sram_mem_ctrl_pkg::*;
#(
   parameter int ADDRESS_LEN   = 32,
   parameter int WORD_LEN      = 32,
   parameter int SRAM_ADDR_W   = 18,
   parameter int SRAM_DATA_W   = 16,
   parameter int ADDR_BASE     = MEM_ADDR_BASE,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_r_en,
   input  logic                   mem_w_en,
   input  logic [ADDRESS_LEN-1:0] addr,
   input  logic [WORD_LEN-1:0]    wdata,
   output logic [WORD_LEN-1:0]    rdata,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   inout  wire  [SRAM_DATA_W-1:0] sram_dq,
   output logic                   sram_we_n
);

   localparam int CW     = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam int WIDX_W = SRAM_ADDR_W - 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

   state_t                   r_state;
   state_t                   w_next;
   logic [CW-1:0]            r_cnt;
   logic [WIDX_W-1:0]        r_widx;
   logic [WORD_LEN-1:0]      r_wdata;
   logic [WORD_LEN-1:0]      r_rdata;

   logic                     w_req;
   logic                     w_last;
   logic                     w_in_lo;
   logic                     w_in_hi;
   logic                     w_in_wr;
   logic                     w_dq_oe;
   logic [SRAM_DATA_W-1:0]   w_dq_out;
   logic [ADDRESS_LEN-1:0]   w_off;
   logic [WIDX_W-1:0]        w_widx;
   logic                     w_unused;

   // Word index relative to the base; the truncation wraps modulo SRAM size
   // and the byte offset bits are dropped.
   assign w_off    = addr - ADDRESS_LEN'(ADDR_BASE);
   assign w_widx   = w_off[WIDX_W+1:2];
   assign w_unused = ^{w_off[ADDRESS_LEN-1:WIDX_W+2], w_off[1:0]};

   assign w_req   = mem_r_en | mem_w_en;
   assign w_last  = (r_cnt == CNT_LAST);
   assign w_in_lo = (r_state == RD_LO) || (r_state == WR_LO);
   assign w_in_hi = (r_state == RD_HI) || (r_state == WR_HI);
   assign w_in_wr = (r_state == WR_LO) || (r_state == WR_HI);

   // Next-state and SRAM strobes; outputs come straight from state so a
   // reset releases the bus in the same cycle.
   always_comb begin
      w_next    = r_state;
      ready     = 1'b0;
      sram_addr = '0;
      sram_we_n = 1'b1;
      w_dq_oe   = 1'b0;
      w_dq_out  = r_wdata[SRAM_DATA_W-1:0];
      case (r_state)
         IDLE: begin
            ready = ~w_req;
            if (mem_w_en)      w_next = WR_LO;
            else if (mem_r_en) w_next = RD_LO;
         end
         RD_LO: if (w_last) w_next = RD_HI;
         RD_HI: if (w_last) w_next = DONE;
         WR_LO: if (w_last) w_next = WR_HI;
         WR_HI: if (w_last) w_next = DONE;
         DONE: begin
            ready  = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      if (w_in_lo) sram_addr = {r_widx, 1'b0};
      if (w_in_hi) sram_addr = {r_widx, 1'b1};
      if (w_in_wr) begin
         w_dq_oe   = 1'b1;
         // Last cycle of a write phase is the address/data hold cycle.
         sram_we_n = w_last;
         if (r_state == WR_HI) w_dq_out = r_wdata[WORD_LEN-1:SRAM_DATA_W];
      end
   end

   assign sram_dq = w_dq_oe ? w_dq_out : {SRAM_DATA_W{1'bz}};
   assign rdata   = r_rdata;

   // State register; phase counter restarts whenever the state changes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) r_cnt <= '0;
         else                   r_cnt <= r_cnt + 1'b1;
      end
   end

   // Latch address and store data when a request is accepted in IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_widx  <= '0;
         r_wdata <= '0;
      end else if (r_state == IDLE && w_req) begin
         r_widx  <= w_widx;
         r_wdata <= wdata;
      end
   end

   // Capture load halves on the final cycle of each read phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= '0;
      end else if (w_last) begin
         if (r_state == RD_LO) r_rdata[SRAM_DATA_W-1:0]        <= sram_dq;
         if (r_state == RD_HI) r_rdata[WORD_LEN-1:SRAM_DATA_W] <= sram_dq;
      end
   end

endmodule
